// File: rtl/du_snapshot_streamer.sv
// du_snapshot_streamer: captures a packed pipeline snapshot on a start pulse and
// streams it out as an optional header byte, the LSB-first payload chunks and an
// optional XOR checksum. Each chunk is offered over a valid/ready handshake
// towards the UART TX FIFO.
module du_snapshot_streamer #(
  parameter int                 NB_SNAP    = 341,
  parameter int                 NB_BYTE    = 8,
  parameter bit                 HEADER_EN  = 1'b1,
  parameter logic [NB_BYTE-1:0] HEADER_VAL = NB_BYTE'(8'hA5),
  parameter bit                 CHKSUM_EN  = 1'b1,
  localparam int                N_CHUNKS   = (NB_SNAP + NB_BYTE - 1) / NB_BYTE,
  localparam int                NB_CNT     = $clog2(N_CHUNKS + 1)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [NB_SNAP-1:0] i_snapshot,
  input  logic               i_tx_ready,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic [NB_CNT-1:0]  o_chunk_idx
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_CHKSUM,
    S_DONE
  } state_e;

  localparam logic [NB_CNT-1:0] LAST_IDX = NB_CNT'(N_CHUNKS - 1);

  state_e                            state_q, state_d;
  logic [N_CHUNKS-1:0][NB_BYTE-1:0]  shadow_q, shadow_d;
  logic [NB_BYTE-1:0]                chk_q, chk_d;
  logic [NB_CNT-1:0]                 idx_q, idx_d;
  logic [N_CHUNKS*NB_BYTE-1:0]       snap_pad;
  logic [NB_BYTE-1:0]                pay_chunk;

  // Zero-extend the snapshot to a whole number of chunks so the last chunk is padded.
  always_comb begin
    snap_pad              = '0;
    snap_pad[NB_SNAP-1:0] = i_snapshot;
  end

  // Select the payload chunk addressed by the current index.
  always_comb begin
    pay_chunk = '0;
    for (int i = 0; i < N_CHUNKS; i++) begin
      if (idx_q == NB_CNT'(i)) pay_chunk = shadow_q[i];
    end
  end

  // Next-state and handshake outputs; outputs are decoded from state only, so
  // data/valid stay stable while the consumer stalls.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    chk_d      = chk_q;
    idx_d      = idx_q;
    o_tx_data  = '0;
    o_tx_valid = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Abort beats start: nothing is captured when both are high.
        if (i_start && !i_abort) begin
          shadow_d = snap_pad;
          chk_d    = '0;
          idx_d    = '0;
          state_d  = HEADER_EN ? S_HEADER : S_PAYLOAD;
        end
      end
      S_HEADER: begin
        o_tx_data  = HEADER_VAL;
        o_tx_valid = 1'b1;
        o_busy     = 1'b1;
        if (i_tx_ready) begin
          idx_d   = '0;
          state_d = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        o_tx_data  = pay_chunk;
        o_tx_valid = 1'b1;
        o_busy     = 1'b1;
        if (i_tx_ready) begin
          chk_d = chk_q ^ pay_chunk;
          // After the last chunk the index rests at N_CHUNKS for CHKSUM/DONE.
          idx_d = idx_q + NB_CNT'(1);
          if (idx_q == LAST_IDX) state_d = CHKSUM_EN ? S_CHKSUM : S_DONE;
        end
      end
      S_CHKSUM: begin
        o_tx_data  = chk_q;
        o_tx_valid = 1'b1;
        o_busy     = 1'b1;
        if (i_tx_ready) state_d = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    // Abort drops any transfer in flight; a chunk taken on this edge is simply gone.
    if (state_q != S_IDLE && i_abort) begin
      idx_d   = '0;
      state_d = S_IDLE;
    end
  end

  assign o_chunk_idx = idx_q;

  // State, shadow image, running checksum and chunk index registers.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      chk_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      chk_q    <= chk_d;
      idx_q    <= idx_d;
    end
  end

endmodule

// File: tb/tb_du_snapshot_streamer.sv
// Bench for du_snapshot_streamer: three instances (12-bit framed, default 341-bit,
// 16-bit unframed) checked against a byte scoreboard fed when each start is driven.
module tb_du_snapshot_streamer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: NB_SNAP=12, header and checksum on
  logic        a_start = 0, a_abort = 0, a_ready = 0;
  logic [11:0] a_snap = '0;
  logic [7:0]  a_data;
  logic        a_valid, a_busy, a_done;
  logic [1:0]  a_idx;
  // Instance B: all defaults
  logic         b_start = 0, b_abort = 0, b_ready = 0;
  logic [340:0] b_snap = '0;
  logic [7:0]   b_data;
  logic         b_valid, b_busy, b_done;
  logic [5:0]   b_idx;
  // Instance C: NB_SNAP=16, no header, no checksum
  logic        c_start = 0, c_abort = 0, c_ready = 0;
  logic [15:0] c_snap = '0;
  logic [7:0]  c_data;
  logic        c_valid, c_busy, c_done;
  logic [1:0]  c_idx;

  du_snapshot_streamer #(.NB_SNAP(12)) u_a (
    .i_clk(clk), .i_reset(rst_n), .i_start(a_start), .i_abort(a_abort),
    .i_snapshot(a_snap), .i_tx_ready(a_ready), .o_tx_data(a_data),
    .o_tx_valid(a_valid), .o_busy(a_busy), .o_done(a_done), .o_chunk_idx(a_idx));

  du_snapshot_streamer u_b (
    .i_clk(clk), .i_reset(rst_n), .i_start(b_start), .i_abort(b_abort),
    .i_snapshot(b_snap), .i_tx_ready(b_ready), .o_tx_data(b_data),
    .o_tx_valid(b_valid), .o_busy(b_busy), .o_done(b_done), .o_chunk_idx(b_idx));

  du_snapshot_streamer #(.NB_SNAP(16), .HEADER_EN(1'b0), .CHKSUM_EN(1'b0)) u_c (
    .i_clk(clk), .i_reset(rst_n), .i_start(c_start), .i_abort(c_abort),
    .i_snapshot(c_snap), .i_tx_ready(c_ready), .o_tx_data(c_data),
    .o_tx_valid(c_valid), .o_busy(c_busy), .o_done(c_done), .o_chunk_idx(c_idx));

  logic [7:0] q_a[$], q_b[$], q_c[$];
  int busy_a, done_a, xfer_a, busy_b, done_b, xfer_b, busy_c, done_c, xfer_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [7:0] act, inout logic [7:0] q[$]);
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s unexpected chunk got %0h expected none", name, act);
    end else begin
      check(name, act, q.pop_front());
    end
  endtask

  // Scoreboard monitors: a handshake seen mid-cycle is a transfer on the next edge.
  always @(negedge clk) if (rst_n) begin
    if (a_valid && a_ready) begin pop_cmp("a_data", a_data, q_a); xfer_a++; end
    if (a_busy) busy_a++;
    if (a_done) done_a++;
  end
  always @(negedge clk) if (rst_n) begin
    if (b_valid && b_ready) begin pop_cmp("b_data", b_data, q_b); xfer_b++; end
    if (b_busy) busy_b++;
    if (b_done) done_b++;
  end
  always @(negedge clk) if (rst_n) begin
    if (c_valid && c_ready) begin pop_cmp("c_data", c_data, q_c); xfer_c++; end
    if (c_busy) busy_c++;
    if (c_done) done_c++;
  end

  typedef struct {
    logic [11:0] snap;
    int          stall;   // ready held low this many cycles while payload chunk 0 is offered
    logic [7:0]  e0, e1, e2, e3;
  } vec_t;

  vec_t vecs[5];

  // Reference stream for the default instance: header, LSB-first chunks, XOR.
  function automatic void push_b(input logic [340:0] s);
    logic [7:0] cs, c;
    q_b.push_back(8'hA5);
    cs = '0;
    for (int i = 0; i < 43; i++) begin
      c = 8'(s >> (i * 8));
      q_b.push_back(c);
      cs ^= c;
    end
    q_b.push_back(cs);
  endfunction

  task automatic run_a(input vec_t v);
    q_a.push_back(v.e0); q_a.push_back(v.e1); q_a.push_back(v.e2); q_a.push_back(v.e3);
    busy_a = 0; done_a = 0; xfer_a = 0;
    a_snap = v.snap; a_start = 1; a_ready = 1;
    @(posedge clk); #1 a_start = 0;
    for (int k = 1; k < 40 && done_a == 0; k++) begin
      a_ready = !(k >= 2 && k < 2 + v.stall);
      @(negedge clk);
      if (k == 1) begin check("a_first_valid", a_valid, 1); check("a_idx_hdr", a_idx, 0); end
      if (k == 2) check("a_idx_p0", a_idx, 0);
      if (k == 4 + v.stall) check("a_idx_chk", a_idx, 2);
      if (!a_ready) begin check("a_hold_valid", a_valid, 1); check("a_hold_data", a_data, v.e1); end
      @(posedge clk); #1;
    end
    a_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("a_done_cnt", done_a, 1);
    check("a_busy_cycles", busy_a, 4 + v.stall);
    check("a_xfers", xfer_a, 4);
    check("a_q_left", q_a.size(), 0);
  endtask

  task automatic run_b(input logic [340:0] s, input bit rnd);
    push_b(s);
    busy_b = 0; done_b = 0; xfer_b = 0;
    b_snap = s; b_start = 1; b_ready = 1;
    @(posedge clk); #1 b_start = 0;
    for (int k = 1; k < 400 && done_b == 0; k++) begin
      b_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (k == 20) b_snap = ~s;
      @(negedge clk);
      if (!rnd && k == 1) check("b_first_valid", b_valid, 1);
      @(posedge clk); #1;
    end
    b_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    check("b_done_cnt", done_b, 1);
    check("b_xfers", xfer_b, 45);
    check("b_q_left", q_b.size(), 0);
    if (!rnd) check("b_busy_cycles", busy_b, 45);
  endtask

  initial begin
    vecs[0] = '{12'hABC, 0, 8'hA5, 8'hBC, 8'h0A, 8'hB6};
    vecs[1] = '{12'hABC, 3, 8'hA5, 8'hBC, 8'h0A, 8'hB6};
    vecs[2] = '{12'h000, 0, 8'hA5, 8'h00, 8'h00, 8'h00};
    vecs[3] = '{12'hFFF, 1, 8'hA5, 8'hFF, 8'h0F, 8'hF0};
    vecs[4] = '{12'h5A3, 2, 8'hA5, 8'hA3, 8'h05, 8'hA6};

    // Reset state
    #2;
    check("rst_a_valid", a_valid, 0); check("rst_a_data", a_data, 0);
    check("rst_a_busy", a_busy, 0);   check("rst_a_done", a_done, 0);
    check("rst_a_idx", a_idx, 0);
    check("rst_b_valid", b_valid, 0); check("rst_b_data", b_data, 0);
    check("rst_c_idx", c_idx, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;

    // Table-driven framed streams with stalls on the first payload chunk
    foreach (vecs[i]) run_a(vecs[i]);

    // Unframed 16-bit stream, snapshot changed after capture
    q_c.push_back(8'h34); q_c.push_back(8'h12);
    busy_c = 0; done_c = 0; xfer_c = 0;
    c_snap = 16'h1234; c_start = 1; c_ready = 1;
    @(posedge clk); #1 c_start = 0; c_snap = 16'hFFFF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("c_idx", c_idx, k - 1);
      if (k == 3) begin check("c_done", c_done, 1); check("c_valid_done", c_valid, 0); end
      @(posedge clk); #1;
    end
    repeat (2) @(posedge clk);
    #1;
    check("c_done_cnt", done_c, 1);
    check("c_busy_cycles", busy_c, 2);
    check("c_q_left", q_c.size(), 0);

    // Default width, all ones, then random snapshot with random backpressure
    run_b({341{1'b1}}, 1'b0);
    begin
      logic [340:0] s;
      s = '0;
      for (int j = 0; j < 11; j++) s = {s[308:0], 32'($urandom)};
      run_b(s, 1'b1);
    end

    // Abort after two payload chunks
    begin
      logic [340:0] s;
      s = {11{31'h1357_9BDF}};
      q_b.push_back(8'hA5); q_b.push_back(8'(s)); q_b.push_back(8'(s >> 8));
      busy_b = 0; done_b = 0; xfer_b = 0;
      b_snap = s; b_start = 1; b_ready = 1;
      @(posedge clk); #1 b_start = 0;
      repeat (3) @(posedge clk);
      #1 b_ready = 0; b_abort = 1;
      @(negedge clk);
      check("b_idx_before_abort", b_idx, 2);
      @(posedge clk); #1 b_abort = 0;
      @(negedge clk);
      check("b_abort_valid", b_valid, 0);
      check("b_abort_busy", b_busy, 0);
      check("b_abort_idx", b_idx, 0);
      repeat (3) @(posedge clk);
      #1;
      check("b_abort_done", done_b, 0);
      check("b_abort_xfers", xfer_b, 3);
      check("b_abort_q_left", q_b.size(), 0);
      run_b(~s, 1'b0);
    end

    // Asynchronous reset while a chunk is stalled
    a_snap = 12'hABC; a_start = 1; a_ready = 0;
    @(posedge clk); #1 a_start = 0;
    @(negedge clk);
    check("a_pre_rst_valid", a_valid, 1);
    #2 rst_n = 0;
    #1;
    check("a_rst_valid", a_valid, 0); check("a_rst_data", a_data, 0);
    check("a_rst_busy", a_busy, 0);   check("a_rst_done", a_done, 0);
    check("a_rst_idx", a_idx, 0);
    @(posedge clk); #1 rst_n = 1; a_ready = 1;
    done_a = 0; busy_a = 0;
    // Start and abort together in IDLE: nothing captured
    a_snap = 12'h123; a_start = 1; a_abort = 1;
    @(posedge clk); #1 a_start = 0; a_abort = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("a_sa_busy", a_busy, 0);
      check("a_sa_valid", a_valid, 0);
      @(posedge clk); #1;
    end
    check("a_sa_done", done_a, 0);
    run_a(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
